// File: rtl/bist_response_analyzer.sv
// ============================================================================
// bist_response_analyzer
//
// Response-side partner of the BIST controller. While the controller holds
// `running`, the CUT response word is folded into a multiple-input signature
// register (MISR) and the compaction cycles are counted. On `finish` the
// block spends one cycle in EVAL comparing the signature and cycle count
// against their golden values. It then holds a pass/fail verdict until the
// next `init` or reset.
//
// Parameters
//   WIDTH       CUT response width and MISR width (>= 2)
//   POLY        MISR feedback mask, applied when the MISR MSB shifts out
//   SEED        MISR value loaded on reset and on init
//   GOLDEN      expected final signature
//   EXP_CYCLES  expected number of running cycles per run
//   CW          cycle counter width, derived from EXP_CYCLES (do not override)
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        asynchronous reset, active low
//   init_i         controller init strobe (highest priority, any state)
//   running_i      controller compaction-enable level
//   finish_i       controller end-of-run strobe
//   cut_out_i      CUT response word, sampled when running_i = 1
//   busy_o         run in progress (ARMED, COMPACT or EVAL), decoded from state
//   done_o         verdict valid, held
//   pass_o         verdict pass, held
//   fail_o         verdict fail, held
//   proto_err_o    sticky protocol violation flag for the current run
//   signature_o    current MISR contents
//   cycle_count_o  saturating compaction cycle counter
//
// State      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | out of reset, no run armed; running/finish are protocol errors
// S_ARMED    | init seen, waiting for the first running cycle or finish
// S_COMPACT  | compacting; gaps in running are allowed
// S_EVAL     | single cycle that computes the verdict
// S_DONE     | verdict, signature and count held until init or reset
// ============================================================================
module bist_response_analyzer #(
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = '0,
    parameter logic [WIDTH-1:0] GOLDEN    = '0,
    parameter int              EXP_CYCLES = 651,
    parameter int              CW         = $clog2(EXP_CYCLES + 1) + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             init_i,
    input  logic             running_i,
    input  logic             finish_i,
    input  logic [WIDTH-1:0] cut_out_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             proto_err_o,
    output logic [WIDTH-1:0] signature_o,
    output logic [CW-1:0]    cycle_count_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_COMPACT = 3'd2;
    localparam logic [2:0] S_EVAL    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] EXP_CNT = CW'(EXP_CYCLES);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] misr_q,  misr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             done_q,  done_d;
    logic             pass_q,  pass_d;
    logic             fail_q,  fail_d;
    logic             perr_q,  perr_d;

    logic [WIDTH-1:0] misr_step;
    logic [CW-1:0]    count_step;
    logic             verdict_ok;
    logic             compact;

    // One MISR shift: the bit leaving the MSB selects the feedback mask, and
    // the whole response word is XORed in on the same cycle.
    assign misr_step  = {misr_q[WIDTH-2:0], 1'b0}
                      ^ (misr_q[WIDTH-1] ? POLY : '0)
                      ^ cut_out_i;

    // Saturate so an overlong run can never wrap back onto EXP_CYCLES.
    assign count_step = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);

    assign verdict_ok = (misr_q == GOLDEN) && (count_q == EXP_CNT) && !perr_q;

    always_comb begin
        state_d = state_q;
        misr_d  = misr_q;
        count_d = count_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        perr_d  = perr_q;
        compact = 1'b0;

        if (init_i) begin
            // init wins over everything, including a simultaneous running.
            state_d = S_ARMED;
            misr_d  = SEED;
            count_d = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            perr_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (running_i || finish_i) begin
                        perr_d = 1'b1;
                    end
                end
                S_ARMED, S_COMPACT: begin
                    if (running_i) begin
                        compact = 1'b1;
                        state_d = S_COMPACT;
                    end
                    // finish with running still compacts that last word, but
                    // the overlap itself is a protocol violation.
                    if (finish_i) begin
                        state_d = S_EVAL;
                        if (running_i) begin
                            perr_d = 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    pass_d  = verdict_ok;
                    fail_d  = !verdict_ok;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (running_i) begin
                        perr_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (compact) begin
            misr_d  = misr_step;
            count_d = count_step;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            misr_q  <= SEED;
            count_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            misr_q  <= misr_d;
            count_q <= count_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            perr_q  <= perr_d;
        end
    end

    assign busy_o        = (state_q == S_ARMED) || (state_q == S_COMPACT) ||
                           (state_q == S_EVAL);
    assign done_o        = done_q;
    assign pass_o        = pass_q;
    assign fail_o        = fail_q;
    assign proto_err_o   = perr_q;
    assign signature_o   = misr_q;
    assign cycle_count_o = count_q;

endmodule
